tx_frame: RTL and testbench
===========================

TX_FRAME -- requirements
Module: tx_frame

Interface
REQ-001 Parameter BIT_CLKS, default 1252, clock cycles per serial bit; matches receiver bit period 2*(625+1); legal range >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries in transmit FIFO; power of two, 2..16.
REQ-003 clock  input  1  system clock; all logic on posedge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 tx_data  input  8  byte to transmit.
REQ-006 tx_valid  input  1  tx_data valid this cycle.
REQ-007 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 tx  output  1  serial line, idle high, registered.
REQ-009 tx_busy  output  1  frame in progress (FSM not IDLE).
REQ-010 tx_done  output  1  one-cycle pulse on last cycle of each stop bit.
REQ-011 fifo_count  output  clog2(FIFO_DEPTH)+1  bytes held in FIFO, excluding the byte being shifted.

Function
REQ-012 Byte accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_valid with tx_ready=0 SHALL be ignored, no data lost or duplicated.
REQ-013 tx_ready SHALL equal (fifo_count < FIFO_DEPTH) and nrst=1.
REQ-014 FIFO SHALL be first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-015 Push and pop on the same edge SHALL leave fifo_count unchanged; push is allowed when full only if a pop occurs on that edge -- not allowed: tx_ready stays low when full.
REQ-016 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly BIT_CLKS cycles; frame exactly 10*BIT_CLKS cycles.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: tx=1; if fifo_count>0, pop head into shift register, set tx=0, reset bit counter, go START on same edge.
REQ-019 START: after BIT_CLKS cycles, drive tx=bit0, go DATA with bit index 0.
REQ-020 DATA: every BIT_CLKS cycles shift to next bit; after bit7 period, drive tx=1, go STOP.
REQ-021 STOP: on last cycle of the stop bit assert tx_done; if fifo_count>0 pop and go START directly (tx=0 next cycle, no idle gap), else go IDLE.
REQ-022 Latency: byte pushed into empty FIFO with FSM IDLE on edge E SHALL cause tx=0 from edge E+1.
REQ-023 Byte pushed on the same edge the FSM finds FIFO empty SHALL be sent on the following edge, not dropped.
REQ-024 Bit counter SHALL count 0..BIT_CLKS-1 and wrap; no counter overflow for any legal BIT_CLKS (width clog2(BIT_CLKS)).
REQ-025 tx_busy=1 in START, DATA, STOP; 0 in IDLE.

Reset
REQ-026 While nrst=0 at a rising edge: FSM to IDLE, FIFO flushed (fifo_count=0, pointers 0), tx=1, tx_busy=0, tx_done=0, tx_ready=0.
REQ-027 Reset mid-frame SHALL abort the frame: tx=1 from the reset edge, no tx_done for the aborted frame, queued bytes discarded.
REQ-028 First edge with nrst=1 after reset SHALL accept a byte (tx_ready=1).

Verification (BIT_CLKS=4, FIFO_DEPTH=4 unless stated)
REQ-029 Push 0xA5 once when idle -> tx from next edge: 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_done one pulse at cycle 40; tx_busy high 40 cycles.
REQ-030 Push 0x00 then 0xFF back-to-back -> two frames with no gap, 80 cycles total, tx_done pulses at cycles 40 and 80, tx high afterward.
REQ-031 Hold tx_valid=1 with bytes 0x01..0x06 while idle -> first byte popped immediately, FIFO fills to 4, tx_ready low until stop of frame 1; all 6 bytes sent in order, none duplicated.
REQ-032 Push on the exact edge STOP ends with empty FIFO -> byte goes out starting next edge, tx high for exactly 1 cycle between frames.
REQ-033 Assert nrst=0 at cycle 15 of a frame with 2 bytes queued -> tx=1, fifo_count=0, tx_busy=0 from that edge; no tx_done; next pushed byte 0x3C sent correctly.
REQ-034 BIT_CLKS=1252 loopback into team receiver with 0xA5, 0x00, 0x5A -> receiver rx_data shows each byte in order.

Source files
------------

// File: rtl/tx_frame.sv
// 8N1 serial transmitter with a small byte FIFO in front of it.
// Bytes queue up through a valid/ready handshake and are sent back to back.
module tx_frame #(
  parameter int BIT_CLKS   = 1252,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          nrst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [FC_W-1:0]  FC_FULL  = FC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [FC_W-1:0]  count;
  logic             push, pop;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shift, shift_nx;
  logic             tx_nx;
  logic             bit_end;

  assign tx_ready   = nrst && (count < FC_FULL);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count;
  assign tx_busy    = (state != IDLE);
  assign bit_end    = (cnt == CNT_LAST);
  assign tx_done    = (state == STOP) && bit_end;

  // FIFO bookkeeping; the FSM only pops when count is non-zero
  always_ff @(posedge clock) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= tx_data;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    tx_nx    = tx;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (count != '0) begin
          pop      = 1'b1;
          shift_nx = mem[rptr];
          tx_nx    = 1'b0;
          cnt_nx   = '0;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_nx    = shift[0];
          shift_nx = shift >> 1;
          idx_nx   = '0;
          cnt_nx   = '0;
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (idx == 3'd7) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            tx_nx    = shift[0];
            shift_nx = shift >> 1;
            idx_nx   = idx + 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        // A queued byte starts its start bit straight after the stop bit
        if (bit_end) begin
          cnt_nx = '0;
          if (count != '0) begin
            pop      = 1'b1;
            shift_nx = mem[rptr];
            tx_nx    = 1'b0;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      tx    <= tx_nx;
    end
  end

  always_ff @(posedge clock) begin
    shift <= shift_nx;
  end

endmodule

// File: tb/tb_tx_frame.sv
// Bench for tx_frame: directed vector table, hand sequences for multi-cycle
// corners, and random traffic checked against a frame-position model.
module tb_tx_frame;

  localparam int B  = 4;
  localparam int D  = 4;
  localparam int FL = 10 * B;

  logic       clock;
  logic       nrst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  tx_frame #(.BIT_CLKS(B), .FIFO_DEPTH(D)) dut (
    .clock      (clock),
    .nrst       (nrst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic pre_ready;

  // Reference model: a byte queue plus a position within the current frame
  logic [7:0] mq[$];
  logic [7:0] m_sent[$];
  bit         m_act = 0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;

  // Serial line decoder sampling mid-bit
  bit         d_act = 0;
  int         d_ph  = 0;
  logic [7:0] d_byte = 8'h00;
  logic [7:0] rx_q[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       e_tx;
    logic       e_busy;
    logic       e_done;
    int         e_cnt;
    logic       e_rdy;
  } vec_t;
  vec_t tbl[$];

  bit exp29 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k >= 9) return 1'b1;
    else return b[3'(k - 1)];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
    int sz;
    if (!r) begin
      mq.delete();
      m_act = 0;
      m_pos = 0;
      return;
    end
    sz = mq.size();
    if (m_act) begin
      if (m_pos == FL - 1) begin
        if (sz > 0) begin
          m_cur = mq.pop_front();
          m_pos = 0;
        end else begin
          m_act = 0;
        end
      end else begin
        m_pos++;
      end
    end else if (sz > 0) begin
      m_cur = mq.pop_front();
      m_act = 1;
      m_pos = 0;
    end
    if (v && sz < D) mq.push_back(d);
    if (m_act && m_pos == FL - 1) m_sent.push_back(m_cur);
  endtask

  task automatic dec_tick(input logic line, input logic r);
    int k;
    if (!r) begin
      d_act = 0;
      return;
    end
    if (!d_act) begin
      if (line == 1'b0) begin
        d_act = 1;
        d_ph  = 0;
      end
      return;
    end
    d_ph++;
    if (d_ph % B == B / 2) begin
      k = d_ph / B;
      if (k == 0) chk("rx_start", 32'(line), 32'(1'b0));
      else if (k <= 8) d_byte[3'(k - 1)] = line;
      else chk("rx_stop", 32'(line), 32'(1'b1));
    end
    if (d_ph == FL - 1) begin
      rx_q.push_back(d_byte);
      d_act = 0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    tx_valid = v;
    tx_data  = d;
    nrst     = r;
    #1;
    pre_ready = tx_ready;
    @(posedge clock);
    model_edge(v, d, r);
    #1;
    cyc++;
    chk("m_tx",    32'(tx),         32'(m_act ? frame_bit(m_cur, m_pos / B) : 1'b1));
    chk("m_busy",  32'(tx_busy),    32'(m_act));
    chk("m_done",  32'(tx_done),    32'(m_act && m_pos == FL - 1));
    chk("m_count", 32'(fifo_count), 32'(mq.size()));
    chk("m_ready", 32'(tx_ready),   32'(r && mq.size() < D));
    dec_tick(tx, r);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic r, input logic etx,
                     input logic ebusy, input logic edone, input int ecnt, input logic erdy);
    vec_t e;
    e.v = v; e.d = d; e.r = r; e.e_tx = etx; e.e_busy = ebusy;
    e.e_done = edone; e.e_cnt = ecnt; e.e_rdy = erdy;
    tbl.push_back(e);
  endtask

  task automatic chk_rx(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_n"}, 32'(rx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      chk({nm, "_byte"}, 32'(rx_q[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] expq[$];
    int         acc;
    bit         burst;
    logic       v, r;

    tx_valid = 1'b0;
    tx_data  = 8'h00;
    nrst     = 1'b0;

    // Reset, single 0xA5 frame, then 0x00/0xFF back to back
    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    for (int k = 1; k <= 42; k++)
      add(1'b0, 8'h00, 1'b1, (k <= 40) ? exp29[(k - 1) / 4] : 1'b1,
          k <= 40, k == 40, 0, 1'b1);
    add(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    for (int k = 2; k <= 82; k++)
      add(1'b0, 8'h00, 1'b1,
          (k <= 40) ? frame_bit(8'h00, (k - 1) / 4) :
          (k <= 80) ? frame_bit(8'hFF, (k - 41) / 4) : 1'b1,
          k <= 80, (k == 40) || (k == 80), (k <= 40) ? 1 : 0, 1'b1);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r);
      chk("t_tx",    32'(tx),         32'(tbl[i].e_tx));
      chk("t_busy",  32'(tx_busy),    32'(tbl[i].e_busy));
      chk("t_done",  32'(tx_done),    32'(tbl[i].e_done));
      chk("t_count", 32'(fifo_count), 32'(tbl[i].e_cnt));
      chk("t_ready", 32'(tx_ready),   32'(tbl[i].e_rdy));
    end

    // Hold valid with 0x01..0x06: FIFO fills, ready drops until frame 1 ends
    rx_q.delete();
    acc = 0;
    for (int c = 0; c < 300; c++) begin
      v = (acc < 6);
      step(v, 8'(acc + 1), 1'b1);
      if (v && pre_ready) acc++;
      if (c == 5)  begin chk("s31_cnt4", 32'(fifo_count), 32'd4); chk("s31_rdy5", 32'(tx_ready), 32'd0); end
      if (c == 40) chk("s31_rdy40", 32'(tx_ready), 32'd0);
      if (c == 41) chk("s31_rdy41", 32'(tx_ready), 32'd1);
    end
    chk("s31_acc", 32'(acc), 32'd6);
    expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    chk_rx("s31_rx", expq);

    // Push on the very edge the stop bit ends with the FIFO empty
    rx_q.delete();
    step(1'b1, 8'h5A, 1'b1);
    for (int c = 1; c <= 40; c++) step(1'b0, 8'h00, 1'b1);
    chk("s32_done40", 32'(tx_done), 32'd1);
    chk("s32_tx40", 32'(tx), 32'd1);
    step(1'b1, 8'hC3, 1'b1);
    chk("s32_tx41", 32'(tx), 32'd1);
    chk("s32_busy41", 32'(tx_busy), 32'd0);
    chk("s32_cnt41", 32'(fifo_count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("s32_tx42", 32'(tx), 32'd0);
    chk("s32_busy42", 32'(tx_busy), 32'd1);
    for (int c = 0; c < 45; c++) step(1'b0, 8'h00, 1'b1);
    expq = '{8'h5A, 8'hC3};
    chk_rx("s32_rx", expq);

    // Reset 15 cycles into a frame with two bytes queued
    rx_q.delete();
    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    chk("s33_cnt2", 32'(fifo_count), 32'd2);
    for (int c = 3; c < 15; c++) step(1'b0, 8'h00, 1'b1);
    chk("s33_busy_pre", 32'(tx_busy), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("s33_tx", 32'(tx), 32'd1);
    chk("s33_cnt", 32'(fifo_count), 32'd0);
    chk("s33_busy", 32'(tx_busy), 32'd0);
    chk("s33_done", 32'(tx_done), 32'd0);
    chk("s33_rdy", 32'(tx_ready), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h3C, 1'b1);
    chk("s33_rdy_first", 32'(pre_ready), 32'd1);
    chk("s33_cnt_after", 32'(fifo_count), 32'd1);
    for (int c = 0; c < 45; c++) step(1'b0, 8'h00, 1'b1);
    expq = '{8'h3C};
    chk_rx("s33_rx", expq);

    // Random traffic with bursts and occasional resets
    rx_q.delete();
    m_sent.delete();
    burst = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) burst = 1'($urandom_range(0, 1));
      v = burst ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 299) != 0);
      step(v, 8'($urandom), r);
    end
    for (int c = 0; c < 500; c++) step(1'b0, 8'($urandom), 1'b1);
    chk_rx("rnd_rx", m_sent);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
